// File: rtl/bus_pkg.sv
// Shared encodings for the external bus arbiter: owner codes and M-cycle phase.
package bus_pkg;

    localparam int OWNER_W = 2;

    typedef enum logic [OWNER_W-1:0] {
        OWNER_CPU  = 2'd0,
        OWNER_DMA  = 2'd1,
        OWNER_HDMA = 2'd2,
        OWNER_BAD  = 2'd3
    } owner_e;

    localparam logic [1:0] CT_LAST = 2'd3;

endpackage

// File: rtl/ext_bus_arbiter.sv
// External bus arbiter: CPU / OAM DMA / HDMA share WRAM, VRAM and cartridge,
// switching owner only on M-cycle boundaries.
//
// owner      | meaning
// -----------+----------------------------------------------------------
// OWNER_CPU  | CPU drives the bus; also the parked state when idle
// OWNER_DMA  | OAM DMA reads the bus; never writes
// OWNER_HDMA | HDMA drives the bus; yields one slot after MAX_HOLD waits
// OWNER_BAD  | unreachable encoding; behaves as CPU, cleared at boundary
module ext_bus_arbiter
    import bus_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  ct,
    input  logic        cpu_req,
    input  logic [15:0] cpu_a,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic        cpu_gnt,
    output logic        cpu_blocked,
    input  logic        dma_req,
    input  logic [15:0] dma_a,
    input  logic        dma_rd,
    output logic        dma_gnt,
    input  logic        hdma_req,
    input  logic        hdma_lock,
    input  logic [15:0] hdma_a,
    input  logic        hdma_rd,
    input  logic        hdma_wr,
    input  logic [7:0]  hdma_dout,
    output logic        hdma_gnt,
    output logic [15:0] a,
    output logic [7:0]  dout,
    output logic        rd,
    output logic        wr,
    output logic [1:0]  owner
);

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    owner_e            owner_q, owner_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              boundary;

    function automatic owner_e select_owner(input logic dma, input logic hdma,
                                            input logic lock, input logic cpu,
                                            input logic at_max);
        if (dma)
            return OWNER_DMA;
        if (hdma && !(at_max && cpu && !lock))
            return OWNER_HDMA;
        return OWNER_CPU;
    endfunction

    assign boundary = (ct == CT_LAST);

    always_comb begin
        owner_d = owner_q;
        hold_d  = hold_q;
        if (boundary) begin
            owner_d = select_owner(dma_req, hdma_req, hdma_lock, cpu_req,
                                   hold_q == MAX_HOLD_C);
            // Counts HDMA slots the CPU sat through; DMA slots leave it alone.
            if (owner_d == OWNER_CPU)
                hold_d = '0;
            else if (owner_d == OWNER_HDMA && cpu_req && hold_q != MAX_HOLD_C)
                hold_d = hold_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWNER_CPU;
            hold_q  <= '0;
        end else begin
            owner_q <= owner_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        a        = cpu_a;
        dout     = cpu_dout;
        rd       = cpu_rd;
        wr       = cpu_wr;
        cpu_gnt  = 1'b1;
        dma_gnt  = 1'b0;
        hdma_gnt = 1'b0;
        case (owner_q)
            OWNER_DMA: begin
                a       = dma_a;
                dout    = 8'h00;
                rd      = dma_rd;
                wr      = 1'b0;
                cpu_gnt = 1'b0;
                dma_gnt = 1'b1;
            end
            OWNER_HDMA: begin
                a        = hdma_a;
                dout     = hdma_dout;
                rd       = hdma_rd;
                wr       = hdma_wr;
                cpu_gnt  = 1'b0;
                hdma_gnt = 1'b1;
            end
            default: ;
        endcase
    end

    assign cpu_blocked = cpu_req & ~cpu_gnt;
    assign owner       = owner_q;

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Directed + randomized bench for ext_bus_arbiter against an M-cycle level
// reference model of ownership and CPU wait streak.
module tb_ext_bus_arbiter;

    localparam int MH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  ct = 2'd0;
    logic        cpu_req = 1'b0, cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [15:0] cpu_a = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic        dma_req = 1'b0, dma_rd = 1'b0;
    logic [15:0] dma_a = 16'h0000;
    logic        hdma_req = 1'b0, hdma_lock = 1'b0, hdma_rd = 1'b0, hdma_wr = 1'b0;
    logic [15:0] hdma_a = 16'h0000;
    logic [7:0]  hdma_dout = 8'h00;
    logic        cpu_gnt, cpu_blocked, dma_gnt, hdma_gnt, rd, wr;
    logic [15:0] a;
    logic [7:0]  dout;
    logic [1:0]  owner;

    ext_bus_arbiter #(.MAX_HOLD(MH), .HOLD_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ct(ct),
        .cpu_req(cpu_req), .cpu_a(cpu_a), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_dout(cpu_dout), .cpu_gnt(cpu_gnt), .cpu_blocked(cpu_blocked),
        .dma_req(dma_req), .dma_a(dma_a), .dma_rd(dma_rd), .dma_gnt(dma_gnt),
        .hdma_req(hdma_req), .hdma_lock(hdma_lock), .hdma_a(hdma_a),
        .hdma_rd(hdma_rd), .hdma_wr(hdma_wr), .hdma_dout(hdma_dout),
        .hdma_gnt(hdma_gnt), .a(a), .dout(dout), .rd(rd), .wr(wr), .owner(owner)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference: who owns the current M-cycle, and how many HDMA slots in a
    // row the CPU has waited through (capped at MH).
    int m_owner = 0;
    int m_wait = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_boundary();
        bit cpu_turn;
        cpu_turn = (m_wait >= MH) && cpu_req && !hdma_lock;
        if (dma_req) begin
            m_owner = 1;
        end else if (hdma_req && !cpu_turn) begin
            m_owner = 2;
            if (cpu_req) m_wait = (m_wait + 1 > MH) ? MH : m_wait + 1;
        end else begin
            m_owner = 0;
            m_wait = 0;
        end
    endtask

    task automatic check_outputs();
        logic [15:0] ea;
        logic [7:0]  ed;
        logic        erd, ewr;
        #1;
        case (m_owner)
            1:       begin ea = dma_a;  ed = 8'h00;     erd = dma_rd;  ewr = 1'b0;    end
            2:       begin ea = hdma_a; ed = hdma_dout; erd = hdma_rd; ewr = hdma_wr; end
            default: begin ea = cpu_a;  ed = cpu_dout;  erd = cpu_rd;  ewr = cpu_wr;  end
        endcase
        chk("owner", 32'(owner), 32'(m_owner));
        chk("cpu_gnt", 32'(cpu_gnt), 32'(m_owner == 0));
        chk("dma_gnt", 32'(dma_gnt), 32'(m_owner == 1));
        chk("hdma_gnt", 32'(hdma_gnt), 32'(m_owner == 2));
        chk("cpu_blocked", 32'(cpu_blocked), 32'(cpu_req && m_owner != 0));
        chk("a", 32'(a), 32'(ea));
        chk("dout", 32'(dout), 32'(ed));
        chk("rd", 32'(rd), 32'(erd));
        chk("wr", 32'(wr), 32'(ewr));
    endtask

    task automatic step();
        bit bnd;
        bnd = (ct == 2'd3);
        @(posedge clk);
        if (bnd && rst_n) model_boundary();
        #1;
        ct = ct + 2'd1;
    endtask

    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check_outputs();
        end
    endtask

    initial begin
        // 1: reset state
        cpu_req = 1'b1; cpu_a = 16'hC123; cpu_rd = 1'b1;
        #2;
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_a", 32'(a), 32'hC123);
        chk("rst_rd", 32'(rd), 32'd1);
        chk("rst_blocked", 32'(cpu_blocked), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; ct = 2'd0;
        run_steps(4);

        // 2: DMA requested mid M-cycle takes over at the next boundary
        step();
        dma_req = 1'b1; dma_a = 16'hC000; dma_rd = 1'b1; cpu_wr = 1'b1; cpu_dout = 8'h5A;
        run_steps(3);
        chk("t2_owner", 32'(owner), 32'd1);
        chk("t2_a", 32'(a), 32'hC000);
        chk("t2_wr", 32'(wr), 32'd0);
        chk("t2_blocked", 32'(cpu_blocked), 32'd1);
        cpu_wr = 1'b0;

        // 3: DMA beats HDMA; HDMA follows once DMA drops
        hdma_req = 1'b1; hdma_a = 16'h8010; hdma_wr = 1'b1; hdma_dout = 8'h3C;
        run_steps(4);
        chk("t3_dma", 32'(owner), 32'd1);
        dma_req = 1'b0; dma_rd = 1'b0;
        run_steps(4);
        chk("t3_hdma", 32'(owner), 32'd2);

        // 4: fairness slot after MH HDMA cycles with the CPU waiting
        hdma_req = 1'b0;
        run_steps(4);
        chk("t4_park", 32'(owner), 32'd0);
        hdma_req = 1'b1;
        for (int m = 0; m < 6; m++) begin
            run_steps(4);
            chk("t4_seq", 32'(owner), (m == 4) ? 32'd0 : 32'd2);
        end

        // 5: lock keeps HDMA on the bus; CPU gets it right after unlock
        hdma_req = 1'b0;
        run_steps(4);
        hdma_req = 1'b1; hdma_lock = 1'b1;
        for (int m = 0; m < 10; m++) begin
            run_steps(4);
            chk("t5_locked", 32'(owner), 32'd2);
        end
        hdma_lock = 1'b0;
        run_steps(4);
        chk("t5_unlock", 32'(owner), 32'd0);

        // 6: asynchronous reset while HDMA owns the bus
        run_steps(4);
        chk("t6_pre", 32'(owner), 32'd2);
        step();
        cpu_rd = 1'b0; cpu_a = 16'hD00D;
        rst_n = 1'b0;
        #1;
        chk("t6_owner", 32'(owner), 32'd0);
        chk("t6_gnt", 32'(cpu_gnt), 32'd1);
        chk("t6_a", 32'(a), 32'hD00D);
        chk("t6_rd", 32'(rd), 32'd0);
        m_owner = 0; m_wait = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; ct = 2'd0;
        for (int m = 0; m < MH + 1; m++) begin
            run_steps(4);
            chk("t6_hold", 32'(owner), (m == MH) ? 32'd0 : 32'd2);
        end

        // Random traffic with changes at arbitrary T-cycles
        for (int i = 0; i < 1200; i++) begin
            step();
            if ($urandom_range(0, 15) == 0) dma_req = ~dma_req;
            if ($urandom_range(0, 5) == 0) hdma_req = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 9) == 0) hdma_lock = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 5) == 0) cpu_req = $urandom_range(0, 3) != 0;
            cpu_a = 16'($urandom); dma_a = 16'($urandom); hdma_a = 16'($urandom);
            cpu_dout = 8'($urandom); hdma_dout = 8'($urandom);
            {cpu_rd, cpu_wr, dma_rd, hdma_rd, hdma_wr} = 5'($urandom);
            check_outputs();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ext_bus_arbiter.md
Name: ext_bus_arbiter

Overview:
- Shares the external bus (WRAM, VRAM, cartridge) between three requesters: the CPU, the OAM DMA engine and a new VRAM block-transfer engine (HDMA).
- Replaces the ad-hoc `dma_occupy_bus` muxing in the top level.
- Ownership changes only on machine-cycle (M-cycle) boundaries, so no requester ever sees a bus switch mid-access.
- Reports to the top-level read mux whether the CPU is blocked, so that CPU reads return 0xFF while blocked.

Parameters:
- MAX_HOLD, 16, consecutive HDMA-owned M-cycles allowed while the CPU is requesting before one CPU M-cycle is forced (1..255).
- HOLD_W, 8, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  in  1  system clock (4.19 MHz).
- rst_n  in  1  reset, asynchronous, active-low.
- ct  in  2  T-cycle index within the M-cycle; 3 marks the last T-cycle.
- cpu_req  in  1  CPU wants the external bus (the top level drives this from address decode 0x0000-0xFDFF).
- cpu_a  in  16  CPU address (early, unbuffered).
- cpu_rd  in  1  CPU read strobe.
- cpu_wr  in  1  CPU write strobe.
- cpu_dout  in  8  CPU write data.
- cpu_gnt  out  1  CPU owns the bus this M-cycle.
- cpu_blocked  out  1  cpu_req high and CPU not owner; top level returns 0xFF to the CPU.
- dma_req  in  1  OAM DMA active.
- dma_a  in  16  DMA source address.
- dma_rd  in  1  DMA read strobe.
- dma_gnt  out  1  DMA owns the bus.
- hdma_req  in  1  HDMA wants the bus.
- hdma_lock  in  1  HDMA is mid-block; suppresses the fairness slot.
- hdma_a  in  16  HDMA address.
- hdma_rd  in  1  HDMA read strobe.
- hdma_wr  in  1  HDMA write strobe.
- hdma_dout  in  8  HDMA write data.
- hdma_gnt  out  1  HDMA owns the bus.
- a  out  16  external address.
- dout  out  8  external write data.
- rd  out  1  external read strobe.
- wr  out  1  external write strobe.
- owner  out  2  current owner: 0 = CPU, 1 = DMA, 2 = HDMA.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: owner = 0 (CPU, parked), hold_cnt = 0, cpu_gnt = 1, dma_gnt = 0, hdma_gnt = 0, cpu_blocked = 0.
- Output mux (combinational, from the registered owner):
  - a, dout, rd, wr are taken from the owner's inputs.
  - DMA owner: wr = 0 and dout = 8'h00; DMA never writes.
  - CPU owner: rd = cpu_rd and wr = cpu_wr, with no gating by cpu_req.
- Grants are one-hot decodes of owner. cpu_blocked = cpu_req & ~cpu_gnt.
- Arbitration is evaluated only on a rising clk edge where ct == 3. The new owner takes effect at ct == 0, i.e. zero-cycle latency into the next M-cycle. Priority order:
  1. dma_req → DMA. DMA always preempts HDMA and CPU at the boundary; the fairness slot does not apply to DMA.
  2. hdma_req, and not (hold_cnt == MAX_HOLD and cpu_req and not hdma_lock) → HDMA.
  3. Otherwise → CPU. The bus parks on the CPU even when nobody requests.
- Hold counter:
  - At each boundary where the new owner is HDMA and cpu_req = 1: hold_cnt increments, saturating at MAX_HOLD.
  - At any boundary where the new owner is CPU: hold_cnt clears.
  - It is held otherwise, including boundaries with DMA owner or with cpu_req = 0.
- Lock: while hdma_lock = 1, HDMA keeps the bus against the CPU regardless of hold_cnt, but DMA still preempts it. When the lock drops with hold_cnt == MAX_HOLD and cpu_req = 1, the next boundary grants the CPU.
- Request drop mid M-cycle: the owner is retained until the next boundary. Bus strobes follow the owner's own rd/wr, so a dropped request with strobes low yields an idle bus.
- Simultaneous dma_req and hdma_req: DMA wins; hold_cnt is held.
- Reset asserted mid-transfer: owner returns to CPU immediately (asynchronously), strobes follow the CPU inputs, and no pending state survives.
- Illegal owner encoding 3: treated as CPU on the outputs, and forced to 0 at the next boundary.

Decomposition:
- Shared package (`bus_pkg`): OWNER_CPU = 2'd0, OWNER_DMA = 2'd1, OWNER_HDMA = 2'd2, OWNER_W = 2, CT_LAST = 2'd3.
- No sub-module needed; the priority select is a single function inside the block. The timer/PPU decode stays in the top level.

Test Plan:
1. Reset, cpu_req = 1, cpu_a = 0xC123, cpu_rd = 1 → owner = 0, a = 0xC123, rd = 1, cpu_blocked = 0.
2. Assert dma_req with dma_a = 0xC000 at ct = 1 → CPU keeps the bus through ct = 3; from the next ct = 0: owner = 1, a = 0xC000, wr = 0 even when cpu_wr = 1, cpu_blocked = 1.
3. dma_req and hdma_req both high across a boundary → owner = 1; drop dma_req → owner = 2 at the following boundary.
4. MAX_HOLD = 4, hdma_req = 1, cpu_req = 1, hdma_lock = 0 → HDMA owns M-cycles 1-4, CPU owns M-cycle 5, HDMA owns M-cycle 6; hold_cnt sequence 1, 2, 3, 4, 0, 1.
5. Same as test 4 with hdma_lock = 1 for 10 M-cycles → HDMA owns all 10; the CPU gets the bus at the first boundary after the lock drops.
6. Pull rst_n low while owner = 2 at ct = 1 → owner = 0 and cpu_gnt = 1 in the same cycle (asynchronous); hold_cnt = 0 after release.
